// File: rtl/rob_commit_pkg.sv
//------------------------------------------------------------------------------
// rob_commit_pkg : shared sizes and entry layout for the reorder buffer
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rob_commit_pkg;

  localparam int ROB_DEPTH      = 8;
  localparam int ROB_ID_WIDTH   = 3;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int WORD_WIDTH     = 32;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      dst_en;
    logic [GPR_ADDR_WIDTH-1:0] dst_addr;
    logic [WORD_WIDTH-1:0]     value;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_lookup_port.sv
//------------------------------------------------------------------------------
// rob_lookup_port : source-operand lookup with same-cycle writeback bypass
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rob_lookup_port
  import rob_commit_pkg::*;
(
  input  logic                    i_entry_valid,
  input  logic                    i_entry_done,
  input  logic [WORD_WIDTH-1:0]   i_entry_value,
  input  logic [ROB_ID_WIDTH-1:0] i_rob_id,
  input  logic                    i_wb_valid,
  input  logic [ROB_ID_WIDTH-1:0] i_wb_rob_id,
  input  logic [WORD_WIDTH-1:0]   i_wb_value,
  output logic                    o_ready,
  output logic [WORD_WIDTH-1:0]   o_value
);

  logic w_wb_hit;

  // A writeback only counts as a hit on a live entry, matching the write path.
  assign w_wb_hit = i_wb_valid && (i_wb_rob_id == i_rob_id) && i_entry_valid;
  assign o_ready  = w_wb_hit || (i_entry_valid && i_entry_done);
  assign o_value  = w_wb_hit ? i_wb_value : i_entry_value;

endmodule

`default_nettype wire

// File: rtl/rob_commit.sv
//------------------------------------------------------------------------------
// rob_commit : in-order reorder buffer driving the GPR commit write port
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  input  logic                      alloc_dst_en,
  input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
  output logic                      alloc_ready,
  output logic [ROB_ID_WIDTH-1:0]   alloc_rob_id,
  input  logic                      wb_valid,
  input  logic [ROB_ID_WIDTH-1:0]   wb_rob_id,
  input  logic [WORD_WIDTH-1:0]     wb_value,
  input  logic [ROB_ID_WIDTH-1:0]   rs1_rob_id,
  input  logic [ROB_ID_WIDTH-1:0]   rs2_rob_id,
  output logic                      rs1_rob_ready,
  output logic                      rs2_rob_ready,
  output logic [WORD_WIDTH-1:0]     rs1_rob_value,
  output logic [WORD_WIDTH-1:0]     rs2_rob_value,
  input  logic                      flush_en,
  output logic                      retire_valid,
  output logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  output logic                      commit_en,
  output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr,
  output logic [WORD_WIDTH-1:0]     rob_commit_dst_value
);

  localparam logic [ROB_ID_WIDTH:0] c_FULL_COUNT = (ROB_ID_WIDTH+1)'(ROB_DEPTH);

  rob_entry_t                r_rob [ROB_DEPTH];
  logic [ROB_ID_WIDTH-1:0]   r_head;
  logic [ROB_ID_WIDTH-1:0]   r_tail;
  logic [ROB_ID_WIDTH:0]     r_count;

  rob_entry_t                w_head_entry;
  logic                      w_alloc_ready;
  logic                      w_alloc_fire;
  logic                      w_retire;
  logic                      w_commit;
  logic [ROB_ID_WIDTH-1:0]   w_rs_id    [2];
  logic                      w_rs_ready [2];
  logic [WORD_WIDTH-1:0]     w_rs_value [2];

  assign w_head_entry  = r_rob[r_head];
  assign w_alloc_ready = (r_count != c_FULL_COUNT);
  assign w_alloc_fire  = alloc_valid && w_alloc_ready && !flush_en;
  assign w_retire      = w_head_entry.valid && w_head_entry.done && !flush_en;
  assign w_commit      = w_retire && w_head_entry.dst_en && (w_head_entry.dst_addr != '0);

  assign alloc_ready          = w_alloc_ready;
  assign alloc_rob_id         = r_tail;
  assign retire_valid         = w_retire;
  assign retire_rob_id        = w_retire ? r_head : '0;
  assign commit_en            = w_commit;
  assign rob_commit_dst_addr  = w_commit ? w_head_entry.dst_addr : '0;
  assign rob_commit_dst_value = w_commit ? w_head_entry.value    : '0;

  // Head and tail never alias on a live retire/alloc pair (empty or full),
  // so the per-entry updates below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else if (flush_en) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i].valid <= 1'b0;
        r_rob[i].done  <= 1'b0;
      end
    end else begin
      if (wb_valid && r_rob[wb_rob_id].valid) begin
        r_rob[wb_rob_id].done  <= 1'b1;
        r_rob[wb_rob_id].value <= wb_value;
      end
      if (w_retire) begin
        r_rob[r_head].valid <= 1'b0;
        r_rob[r_head].done  <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_alloc_fire) begin
        r_rob[r_tail].valid    <= 1'b1;
        r_rob[r_tail].done     <= 1'b0;
        r_rob[r_tail].dst_en   <= alloc_dst_en;
        r_rob[r_tail].dst_addr <= alloc_dst_addr;
        r_tail                 <= r_tail + 1'b1;
      end
      case ({w_alloc_fire, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_rs_id[0]    = rs1_rob_id;
  assign w_rs_id[1]    = rs2_rob_id;
  assign rs1_rob_ready = w_rs_ready[0];
  assign rs2_rob_ready = w_rs_ready[1];
  assign rs1_rob_value = w_rs_value[0];
  assign rs2_rob_value = w_rs_value[1];

  for (genvar g = 0; g < 2; g++) begin : g_lookup
    rob_lookup_port u_port (
      .i_entry_valid (r_rob[w_rs_id[g]].valid),
      .i_entry_done  (r_rob[w_rs_id[g]].done),
      .i_entry_value (r_rob[w_rs_id[g]].value),
      .i_rob_id      (w_rs_id[g]),
      .i_wb_valid    (wb_valid),
      .i_wb_rob_id   (wb_rob_id),
      .i_wb_value    (wb_value),
      .o_ready       (w_rs_ready[g]),
      .o_value       (w_rs_value[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
//------------------------------------------------------------------------------
// tb_rob_commit : directed plus random stimulus against an in-order queue model
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rob_commit;
  import rob_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_dst_en, alloc_ready;
  logic [4:0]  alloc_dst_addr;
  logic [2:0]  alloc_rob_id;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_value;
  logic [2:0]  rs1_rob_id, rs2_rob_id;
  logic        rs1_rob_ready, rs2_rob_ready;
  logic [31:0] rs1_rob_value, rs2_rob_value;
  logic        flush_en;
  logic        retire_valid, commit_en;
  logic [2:0]  retire_rob_id;
  logic [4:0]  rob_commit_dst_addr;
  logic [31:0] rob_commit_dst_value;

  always #10 clk = ~clk;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dst_en(alloc_dst_en), .alloc_dst_addr(alloc_dst_addr),
    .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .rs1_rob_id(rs1_rob_id), .rs2_rob_id(rs2_rob_id),
    .rs1_rob_ready(rs1_rob_ready), .rs2_rob_ready(rs2_rob_ready),
    .rs1_rob_value(rs1_rob_value), .rs2_rob_value(rs2_rob_value),
    .flush_en(flush_en), .retire_valid(retire_valid), .retire_rob_id(retire_rob_id),
    .commit_en(commit_en), .rob_commit_dst_addr(rob_commit_dst_addr),
    .rob_commit_dst_value(rob_commit_dst_value)
  );

  // Program-order model: front of the queue is the oldest live instruction.
  typedef struct {
    logic [2:0]  id;
    logic        den;
    logic [4:0]  dad;
    logic        done;
    logic [31:0] val;
  } mrec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  id;
    logic        cen;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  mrec_t      rob_q[$];
  exp_t       exp_q[$];
  logic [2:0] m_tail = '0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic int find_idx(input logic [2:0] id);
    foreach (rob_q[i]) if (rob_q[i].id == id) return i;
    return -1;
  endfunction

  task automatic step(input bit av, input bit aen, input logic [4:0] aaddr,
                      input bit wv, input logic [2:0] wid, input logic [31:0] wval,
                      input logic [2:0] r1, input logic [2:0] r2, input bit fl);
    int       idx;
    bit       hit, erdy, ret, full;
    logic [2:0] id;
    exp_t     e;
    mrec_t    m;
    @(negedge clk);
    cyc++;
    alloc_valid = av; alloc_dst_en = aen; alloc_dst_addr = aaddr;
    wb_valid = wv; wb_rob_id = wid; wb_value = wval;
    rs1_rob_id = r1; rs2_rob_id = r2; flush_en = fl;
    #1;
    full = (rob_q.size() >= ROB_DEPTH);
    chk("alloc_ready", alloc_ready, !full);
    chk("alloc_rob_id", alloc_rob_id, m_tail);
    for (int p = 0; p < 2; p++) begin
      id   = (p == 0) ? r1 : r2;
      idx  = find_idx(id);
      hit  = wv && (wid == id) && (idx >= 0);
      erdy = (idx >= 0) && (hit || rob_q[idx].done);
      chk(p == 0 ? "rs1_ready" : "rs2_ready", p == 0 ? rs1_rob_ready : rs2_rob_ready, erdy);
      if (erdy)
        chk(p == 0 ? "rs1_value" : "rs2_value", p == 0 ? rs1_rob_value : rs2_rob_value,
            hit ? wval : rob_q[idx].val);
    end
    ret = !fl && (rob_q.size() > 0) && rob_q[0].done;
    if (ret) begin
      e.cyc  = cyc;
      e.id   = rob_q[0].id;
      e.cen  = rob_q[0].den && (rob_q[0].dad != 0);
      e.addr = e.cen ? rob_q[0].dad : 5'd0;
      e.val  = e.cen ? rob_q[0].val : 32'd0;
      exp_q.push_back(e);
    end
    if (fl) begin
      rob_q.delete();
      m_tail = '0;
    end else begin
      idx = find_idx(wid);
      if (wv && idx >= 0) begin
        m = rob_q[idx]; m.done = 1'b1; m.val = wval; rob_q[idx] = m;
      end
      if (ret) void'(rob_q.pop_front());
      if (av && !full) begin
        m.id = m_tail; m.den = aen; m.dad = aaddr; m.done = 1'b0; m.val = '0;
        rob_q.push_back(m);
        m_tail = m_tail + 3'd1;
      end
    end
  endtask

  task automatic idle(input logic [2:0] r1 = 3'd0);
    step(0, 0, 5'd0, 0, 3'd0, 32'd0, r1, 3'd0, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_rob_id", alloc_rob_id, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_retire_rob_id", retire_rob_id, 0);
    chk("rst_commit_en", commit_en, 0);
    chk("rst_dst_addr", rob_commit_dst_addr, 0);
    chk("rst_dst_value", rob_commit_dst_value, 0);
    chk("rst_rs1_ready", rs1_rob_ready, 0);
    chk("rst_rs2_ready", rs2_rob_ready, 0);
    chk("rst_rs1_value", rs1_rob_value, 0);
    chk("rst_rs2_value", rs2_rob_value, 0);
  endtask

  // Called right after a step: reset lands after the monitor has sampled.
  task automatic do_reset();
    #4 rst_n = 1'b0;
    #1 chk_reset_outputs();
    rob_q.delete();
    m_tail = '0;
    #2 rst_n = 1'b1;
  endtask

  task automatic rand_step();
    bit         av, wv, fl;
    logic [2:0] wid, r1, r2;
    logic [4:0] aaddr;
    av    = ($urandom_range(0, 9) < 6);
    wv    = ($urandom_range(0, 1) == 1);
    fl    = ($urandom_range(0, 39) == 0);
    aaddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
      wid = rob_q[$urandom_range(0, rob_q.size() - 1)].id;
    else
      wid = 3'($urandom);
    r1 = ($urandom_range(0, 3) == 0) ? wid : 3'($urandom);
    r2 = 3'($urandom);
    step(av, 1'($urandom), aaddr, wv, wid, $urandom, r1, r2, fl);
  endtask

  // Retire monitor: pops the scoreboard whenever the DUT retires.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (retire_valid) begin
          if (exp_q.size() == 0) chk("unexpected_retire", retire_rob_id, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("retire_cycle", cyc, e.cyc);
            chk("retire_rob_id", retire_rob_id, e.id);
            chk("commit_en", commit_en, e.cen);
            chk("commit_dst_addr", rob_commit_dst_addr, e.addr);
            chk("commit_dst_value", rob_commit_dst_value, e.val);
          end
        end else begin
          chk("idle_commit_en", commit_en, 0);
          chk("idle_dst_addr", rob_commit_dst_addr, 0);
          chk("idle_dst_value", rob_commit_dst_value, 0);
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_retire", 0, 1);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alloc_valid = 0; alloc_dst_en = 0; alloc_dst_addr = '0;
    wb_valid = 0; wb_rob_id = '0; wb_value = '0;
    rs1_rob_id = '0; rs2_rob_id = '0; flush_en = 0;
    #2 chk_reset_outputs();
    #13 rst_n = 1'b1;

    // Basic commit
    step(1, 1, 5'd5, 0, 3'd0, 32'd0, 3'd0, 3'd0, 0);
    step(0, 0, 5'd0, 1, 3'd0, 32'hDEADBEEF, 3'd0, 3'd0, 0);
    idle(); idle();
    do_reset();

    // In-order retire with out-of-order completion
    step(1, 1, 5'd1, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(1, 1, 5'd2, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(1, 1, 5'd3, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(0, 0, 5'd0, 1, 3'd2, 32'h22, 3'd2, 3'd1, 0);
    step(0, 0, 5'd0, 1, 3'd1, 32'h11, 3'd2, 3'd1, 0);
    idle();
    step(0, 0, 5'd0, 1, 3'd0, 32'h10, 3'd0, 3'd1, 0);
    idle(); idle(); idle(); idle();
    do_reset();

    // Full, dropped alloc, wrap
    for (int i = 0; i < 9; i++) step(1, 1, 5'(i + 1), 0, 3'd0, 0, 3'd0, 3'd7, 0);
    step(0, 0, 5'd0, 1, 3'd0, 32'hA5A5_0000, 3'd0, 3'd7, 0);
    idle();
    step(1, 1, 5'd9, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    idle();
    do_reset();

    // x0 destination and no destination
    step(1, 1, 5'd0, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(1, 0, 5'd7, 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(0, 0, 5'd0, 1, 3'd0, 32'h5555, 3'd0, 3'd1, 0);
    step(0, 0, 5'd0, 1, 3'd1, 32'h6666, 3'd0, 3'd1, 0);
    idle(); idle();
    do_reset();

    // Lookup bypass, then flush with a done head
    for (int i = 0; i < 4; i++) step(1, 1, 5'(i + 10), 0, 3'd0, 0, 3'd0, 3'd0, 0);
    step(0, 0, 5'd0, 1, 3'd3, 32'h1234, 3'd3, 3'd2, 0);
    idle(3'd3);
    step(0, 0, 5'd0, 1, 3'd0, 32'hCAFE, 3'd0, 3'd3, 0);
    step(1, 1, 5'd4, 1, 3'd1, 32'hBEEF, 3'd0, 3'd3, 1);
    idle(3'd3);

    repeat (1500) rand_step();
    do_reset();
    repeat (400) rand_step();

    @(negedge clk);
    #5 chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
